// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: start bit, LSB-first payload, optional parity, 1-2 stop bits.
// One frame in flight; requests while busy are dropped. TxD is registered.
module uart_tx_framed #(
  parameter int unsigned CLK_DIV   = 5208,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 1,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] data,
  output logic                 TxD,
  output logic                 ready,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par, par_n;
  logic                 txd_n;
  logic                 done_n;
  logic                 accept;
  logic                 bit_end;

  assign ready   = (state == ST_IDLE);
  assign busy    = !ready;
  assign accept  = transmit & ready;
  assign bit_end = (cnt == CNT_LAST);

  // TxD is computed one step ahead so the register holds the bit for the
  // state being entered; the start bit therefore appears right after acceptance.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par;
    txd_n   = TxD;
    done_n  = 1'b0;

    if (state != ST_IDLE) begin
      cnt_n = bit_end ? '0 : cnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        txd_n = 1'b1;
        if (accept) begin
          state_n = ST_START;
          cnt_n   = '0;
          idx_n   = '0;
          shreg_n = data;
          par_n   = (^data) ^ (PARITY == 2);
          txd_n   = 1'b0;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
          txd_n   = shreg[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (idx == IDX_LAST) begin
            idx_n = '0;
            if (PARITY != 0) begin
              state_n = ST_PARITY;
              txd_n   = par;
            end else begin
              state_n = ST_STOP;
              txd_n   = 1'b1;
            end
          end else begin
            idx_n   = idx + 1'b1;
            shreg_n = shreg >> 1;
            txd_n   = shreg[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_n = ST_STOP;
          txd_n   = 1'b1;
        end
      end

      ST_STOP: begin
        txd_n = 1'b1;
        if (bit_end) begin
          if (idx == STOP_LAST) begin
            state_n = ST_IDLE;
            idx_n   = '0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        txd_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      par   <= 1'b0;
      TxD   <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      par   <= par_n;
      TxD   <= txd_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: three configurations (8E1, 7N2, 8O1) at CLK_DIV=4,
// hand-built frame table, random frames against a bit-list model, corner sequences.
module tb_uart_tx_framed;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] tx_v;
  logic [7:0] data_v [3];

  logic txd0, txd1, txd2;
  logic rdy0, rdy1, rdy2;
  logic bsy0, bsy1, bsy2;
  logic dn0, dn1, dn2;
  logic [2:0] txd_v, ready_v, busy_v, done_v;

  assign txd_v   = {txd2, txd1, txd0};
  assign ready_v = {rdy2, rdy1, rdy0};
  assign busy_v  = {bsy2, bsy1, bsy0};
  assign done_v  = {dn2, dn1, dn0};

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  uart_tx_framed #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .transmit(tx_v[0]), .data(data_v[0]),
    .TxD(txd0), .ready(rdy0), .busy(bsy0), .done(dn0));

  uart_tx_framed #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_none (
    .clk(clk), .reset(reset), .transmit(tx_v[1]), .data(data_v[1][6:0]),
    .TxD(txd1), .ready(rdy1), .busy(bsy1), .done(dn1));

  uart_tx_framed #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(reset), .transmit(tx_v[2]), .data(data_v[2]),
    .TxD(txd2), .ready(rdy2), .busy(bsy2), .done(dn2));

  function automatic int db_of(input int u);
    return (u == 1) ? 7 : 8;
  endfunction

  function automatic int par_of(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 0 : 2);
  endfunction

  function automatic int sb_of(input int u);
    return (u == 1) ? 2 : 1;
  endfunction

  // Reference frame as a list of line levels, one entry per bit period.
  task automatic build(input int u, input logic [7:0] d,
                       output logic [15:0] seq, output int nbits);
    int n;
    int ones;
    n    = 0;
    ones = 0;
    seq  = '1;
    seq[n] = 1'b0;
    n++;
    for (int i = 0; i < db_of(u); i++) begin
      seq[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (par_of(u) != 0) begin
      seq[n] = ((ones % 2) == 1) ^ (par_of(u) == 2);
      n++;
    end
    for (int i = 0; i < sb_of(u); i++) begin
      seq[n] = 1'b1;
      n++;
    end
    nbits = n;
  endtask

  task automatic chk(input string nm, input int u, input int k,
                     input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s unit%0d cycle%0d: got %b want %b", nm, u, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame and checks every cycle of it plus the done cycle and the one after.
  // poke >= 0 raises transmit with 0xA3 for one cycle at that frame cycle.
  task automatic run_frame(input int u, input logic [7:0] d, input logic [15:0] seq,
                           input int nbits, input int poke);
    chk("ready_pre", u, -1, ready_v[u], 1'b1);
    tx_v[u]   = 1'b1;
    data_v[u] = d;
    step();
    tx_v[u]   = 1'b0;
    data_v[u] = 8'($urandom);
    for (int k = 0; k < nbits * CD; k++) begin
      if (k == poke) begin
        tx_v[u]   = 1'b1;
        data_v[u] = 8'hA3;
      end else if (k == poke + 1) begin
        tx_v[u] = 1'b0;
      end
      chk("txd", u, k, txd_v[u], seq[k / CD]);
      chk("busy", u, k, busy_v[u], 1'b1);
      chk("done_lo", u, k, done_v[u], 1'b0);
      step();
    end
    chk("done_pulse", u, nbits * CD, done_v[u], 1'b1);
    chk("ready_end", u, nbits * CD, ready_v[u], 1'b1);
    chk("txd_end", u, nbits * CD, txd_v[u], 1'b1);
    step();
    chk("done_clr", u, nbits * CD + 1, done_v[u], 1'b0);
    chk("txd_idle", u, nbits * CD + 1, txd_v[u], 1'b1);
  endtask

  typedef struct {
    int          u;
    logic [7:0]  d;
    logic [15:0] seq;
    int          nbits;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [15:0] seq1, seq2;
    int          nb1, nb2, u, poke;
    logic [7:0]  d1, d2;

    // seq bit i is the i-th bit on the line
    tbl[0] = '{0, 8'h55, 16'h04AA, 11};
    tbl[1] = '{0, 8'h01, 16'h0602, 11};
    tbl[2] = '{2, 8'h01, 16'h0402, 11};
    tbl[3] = '{1, 8'h7F, 16'h03FE, 10};
    tbl[4] = '{2, 8'h00, 16'h0600, 11};
    tbl[5] = '{0, 8'hFF, 16'h05FE, 11};
    tbl[6] = '{1, 8'h2A, 16'h0354, 10};

    reset = 1'b1;
    tx_v  = '0;
    for (int i = 0; i < 3; i++) data_v[i] = '0;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      chk("rst_txd", i, 0, txd_v[i], 1'b1);
      chk("rst_ready", i, 0, ready_v[i], 1'b1);
      chk("rst_busy", i, 0, busy_v[i], 1'b0);
      chk("rst_done", i, 0, done_v[i], 1'b0);
    end

    // A request during reset must not be accepted.
    tx_v = '1;
    for (int i = 0; i < 3; i++) data_v[i] = 8'h00;
    step();
    reset = 1'b0;
    tx_v  = '0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_prio_ready", i, 0, ready_v[i], 1'b1);
      chk("rst_prio_txd", i, 0, txd_v[i], 1'b1);
    end
    step();
    for (int i = 0; i < 3; i++) chk("rst_prio_idle", i, 1, txd_v[i], 1'b1);

    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].u, tbl[i].d, tbl[i].seq, tbl[i].nbits, -1);
      step();
    end

    // Request during data bits is ignored and the new payload never appears.
    run_frame(0, 8'h55, tbl[0].seq, tbl[0].nbits, 13);
    for (int k = 0; k < 8; k++) begin
      chk("ignored_txd", 0, k, txd_v[0], 1'b1);
      chk("ignored_ready", 0, k, ready_v[0], 1'b1);
      step();
    end

    // Reset in the third data bit aborts the frame without a done pulse.
    tx_v[0]   = 1'b1;
    data_v[0] = 8'h55;
    step();
    tx_v[0] = 1'b0;
    for (int k = 0; k < 13; k++) begin
      chk("abort_txd", 0, k, txd_v[0], tbl[0].seq[k / CD]);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_txd_hi", 0, 0, txd_v[0], 1'b1);
    chk("abort_ready", 0, 0, ready_v[0], 1'b1);
    chk("abort_busy", 0, 0, busy_v[0], 1'b0);
    for (int k = 0; k < 60; k++) begin
      chk("abort_no_done", 0, k, done_v[0], 1'b0);
      chk("abort_idle", 0, k, txd_v[0], 1'b1);
      step();
    end
    run_frame(0, 8'h55, tbl[0].seq, tbl[0].nbits, -1);
    step();

    // Back-to-back with transmit held high: one idle-high cycle between frames.
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    build(0, d1, seq1, nb1);
    build(0, d2, seq2, nb2);
    tx_v[0]   = 1'b1;
    data_v[0] = d1;
    step();
    data_v[0] = d2;
    for (int k = 0; k < nb1 * CD; k++) begin
      chk("b2b_txd1", 0, k, txd_v[0], seq1[k / CD]);
      chk("b2b_done1_lo", 0, k, done_v[0], 1'b0);
      step();
    end
    chk("b2b_gap_txd", 0, nb1 * CD, txd_v[0], 1'b1);
    chk("b2b_gap_done", 0, nb1 * CD, done_v[0], 1'b1);
    chk("b2b_gap_ready", 0, nb1 * CD, ready_v[0], 1'b1);
    step();
    tx_v[0] = 1'b0;
    for (int k = 0; k < nb2 * CD; k++) begin
      chk("b2b_txd2", 0, k, txd_v[0], seq2[k / CD]);
      chk("b2b_busy2", 0, k, busy_v[0], 1'b1);
      step();
    end
    chk("b2b_done2", 0, nb2 * CD, done_v[0], 1'b1);
    step();
    chk("b2b_done2_clr", 0, 0, done_v[0], 1'b0);
    chk("b2b_ready_end", 0, 0, ready_v[0], 1'b1);
    step();

    for (int i = 0; i < 30; i++) begin
      u  = int'($urandom_range(0, 2));
      d1 = 8'($urandom);
      build(u, d1, seq1, nb1);
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(CD, nb1 * CD - 3)) : -1;
      run_frame(u, d1, seq1, nb1, poke);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want $finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
